// File: rtl/sw_debounce_tick_if.sv
// Switch/sequencer-control bundle: raw switch in, debounced mode and step tick out.
interface sw_debounce_tick_if;
  logic sw;
  logic mode;
  logic tick;
  logic mode_changed;

  modport master (
    output sw,
    input  mode,
    input  tick,
    input  mode_changed
  );

  modport slave (
    input  sw,
    output mode,
    output tick,
    output mode_changed
  );
endinterface

// File: rtl/sw_debounce_tick.sv
// Mode-switch debouncer plus step-tick prescaler feeding an LED sequencer.
// An accepted mode change restarts the tick cadence so the sequencer steps in phase with the new mode.
module sw_debounce_tick #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 8
) (
  input  logic              clk,
  input  logic              reset,
  sw_debounce_tick_if.slave bus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [DW-1:0] DC_ZERO = DW'(0);
  localparam logic [DW-1:0] DC_ONE  = DW'(1);
  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PC_ZERO = PW'(0);
  localparam logic [PW-1:0] PC_ONE  = PW'(1);
  localparam logic [PW-1:0] PC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic          sw_s1;
  logic          sw_s2;
  state_t        state;
  state_t        state_next;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_next;
  logic [PW-1:0] pcnt;
  logic          accept;
  logic          mode_next;
  logic          mode_q;
  logic          tick_q;
  logic          mode_changed_q;

  // Two-flop synchronizer for the asynchronous switch input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1 <= 1'b0;
      sw_s2 <= 1'b0;
    end else begin
      sw_s1 <= bus.sw;
      sw_s2 <= sw_s1;
    end
  end

  // Debounce FSM state and stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STABLE_LO;
      dcnt  <= DC_ZERO;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
    end
  end

  // The first differing sample already counts as one, so acceptance lands on the DEBOUNCE_CYCLES-th
  always_comb begin
    state_next = state;
    dcnt_next  = DC_ZERO;
    accept     = 1'b0;
    mode_next  = mode_q;
    case (state)
      STABLE_LO: begin
        if (sw_s2) begin
          state_next = WAIT_HI;
          dcnt_next  = DC_ONE;
        end else begin
          dcnt_next  = DC_ZERO;
        end
      end
      WAIT_HI: begin
        if (!sw_s2) begin
          state_next = STABLE_LO;
          dcnt_next  = DC_ZERO;
        end else if (dcnt == DC_LAST) begin
          state_next = STABLE_HI;
          dcnt_next  = DC_ZERO;
          accept     = 1'b1;
          mode_next  = 1'b1;
        end else begin
          dcnt_next  = dcnt + DC_ONE;
        end
      end
      STABLE_HI: begin
        if (!sw_s2) begin
          state_next = WAIT_LO;
          dcnt_next  = DC_ONE;
        end else begin
          dcnt_next  = DC_ZERO;
        end
      end
      WAIT_LO: begin
        if (sw_s2) begin
          state_next = STABLE_HI;
          dcnt_next  = DC_ZERO;
        end else if (dcnt == DC_LAST) begin
          state_next = STABLE_LO;
          dcnt_next  = DC_ZERO;
          accept     = 1'b1;
          mode_next  = 1'b0;
        end else begin
          dcnt_next  = dcnt + DC_ONE;
        end
      end
      default: begin
        state_next = STABLE_LO;
        dcnt_next  = DC_ZERO;
      end
    endcase
  end

  // Prescaler and registered outputs; a mode change wins over a coincident wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt           <= PC_ZERO;
      tick_q         <= 1'b0;
      mode_q         <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      mode_q         <= mode_next;
      mode_changed_q <= accept;
      if (accept) begin
        pcnt   <= PC_ZERO;
        tick_q <= 1'b0;
      end else if (pcnt == PC_LAST) begin
        pcnt   <= PC_ZERO;
        tick_q <= 1'b1;
      end else begin
        pcnt   <= pcnt + PC_ONE;
        tick_q <= 1'b0;
      end
    end
  end

  assign bus.mode         = mode_q;
  assign bus.tick         = tick_q;
  assign bus.mode_changed = mode_changed_q;

endmodule

// File: tb/tb_sw_debounce_tick.sv
// Scoreboard bench for sw_debounce_tick: expected tick and mode-change cycles are queued as stimulus is driven.
module tb_sw_debounce_tick;

  localparam int DC  = 4;
  localparam int TD  = 8;
  localparam int LAT = DC + 2;

  typedef struct {
    int   c;
    logic m;
  } mc_ev_t;

  logic clk;
  logic reset;

  sw_debounce_tick_if bus_if ();

  sw_debounce_tick #(
    .DEBOUNCE_CYCLES(DC),
    .TICK_DIV       (TD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int     checks   = 0;
  int     failures = 0;
  int     cyc;
  int     base;
  logic   exp_mode;
  int     tick_q[$];
  int     restart_q[$];
  mc_ev_t mc_q[$];

  initial clk = 1'b1;
  always #10 clk = ~clk;

  // Rising-edge count since the last reset release
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    tick_q.delete();
    mc_q.delete();
    restart_q.delete();
    base     = 0;
    exp_mode = 1'b0;
  endtask

  // Drive sw for the next edge and queue whether that edge should produce a tick
  task automatic step(input logic v);
    int c;
    @(negedge clk);
    bus_if.sw = v;
    c = cyc + 1;
    if (restart_q.size() > 0 && restart_q[0] == c) begin
      base = c;
      void'(restart_q.pop_front());
    end else if ((c - base) % TD == 0) begin
      tick_q.push_back(c);
    end
  endtask

  task automatic expect_change(input int e, input logic m);
    mc_ev_t ev;
    ev.c = e;
    ev.m = m;
    mc_q.push_back(ev);
    restart_q.push_back(e);
  endtask

  // Per-cycle comparison of DUT outputs against the queued expectations
  initial begin
    logic exp_tick;
    logic exp_mc;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        exp_tick = (tick_q.size() > 0 && tick_q[0] == cyc);
        if (exp_tick) void'(tick_q.pop_front());
        exp_mc = (mc_q.size() > 0 && mc_q[0].c == cyc);
        if (exp_mc) begin
          exp_mode = mc_q[0].m;
          void'(mc_q.pop_front());
        end
        chk("tick", bus_if.tick, exp_tick);
        chk("mode_changed", bus_if.mode_changed, exp_mc);
        chk("mode", bus_if.mode, exp_mode);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus_if.sw = 1'b0;
    clear_model();
    #15;
    chk("rst_mode", bus_if.mode, 1'b0);
    chk("rst_tick", bus_if.tick, 1'b0);
    chk("rst_mc", bus_if.mode_changed, 1'b0);
    #15;
    reset = 1'b0;
    #5;

    // Idle: ticks on edges 8, 16, 24
    repeat (26) step(1'b0);

    // Clean rise, then the tick cadence restarts at the change
    step(1'b1);
    expect_change(cyc + LAT, 1'b1);
    repeat (20) step(1'b1);

    // Clean fall, then a 2-cycle high glitch that must be rejected
    step(1'b0);
    expect_change(cyc + LAT, 1'b0);
    repeat (16) step(1'b0);
    step(1'b1);
    step(1'b1);
    repeat (20) step(1'b0);

    // Acceptance coinciding with the prescaler wrap
    while ((cyc + 1 + LAT - base) % TD != 0) step(1'b0);
    step(1'b1);
    expect_change(cyc + LAT, 1'b1);
    repeat (20) step(1'b1);

    // Short low glitch while high must be rejected
    repeat (3) step(1'b0);
    repeat (12) step(1'b1);

    // Fall, then 1-cycle bounces before a stable high
    step(1'b0);
    expect_change(cyc + LAT, 1'b0);
    repeat (14) step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    expect_change(cyc + LAT, 1'b1);
    repeat (20) step(1'b1);

    // Reset while in WAIT_LO with mode high: immediate clear, no pulse afterwards
    repeat (3) step(1'b0);
    @(posedge clk);
    #5;
    reset     = 1'b1;
    bus_if.sw = 1'b0;
    #1;
    chk("async_lo_mode", bus_if.mode, 1'b0);
    chk("async_lo_tick", bus_if.tick, 1'b0);
    chk("async_lo_mc", bus_if.mode_changed, 1'b0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) step(1'b0);

    // Reset two cycles into WAIT_HI with sw low at release
    repeat (4) step(1'b1);
    @(posedge clk);
    #5;
    reset     = 1'b1;
    bus_if.sw = 1'b0;
    #1;
    chk("async_hi_mode", bus_if.mode, 1'b0);
    chk("async_hi_tick", bus_if.tick, 1'b0);
    chk("async_hi_mc", bus_if.mode_changed, 1'b0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) step(1'b0);

    // Release with sw already high: mode rises on edge LAT
    #5;
    reset     = 1'b1;
    bus_if.sw = 1'b1;
    clear_model();
    expect_change(LAT, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) step(1'b1);

    @(posedge clk);
    #3;
    chk("tick_q_left", tick_q.size(), 0);
    chk("mc_q_left", mc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_debounce_tick.md
SW_DEBOUNCE_TICK -- requirements
Module: sw_debounce_tick

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required to accept a switch change; legal range 2..65535.
REQ-002 Parameter TICK_DIV, default 8: prescaler period in clk cycles between step ticks; legal range 2..2^24.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sw  input  1  raw mechanical mode switch, asynchronous to clk, may bounce.
REQ-006 mode  output  1  debounced switch level; drives the mode input of the LED sequencer downstream.
REQ-007 tick  output  1  one-cycle step-enable pulse for the LED sequencer.
REQ-008 mode_changed  output  1  one-cycle pulse in the same cycle mode takes its new value.

Function
REQ-009 sw SHALL pass through a two-flop synchronizer (sw_s1, sw_s2); only sw_s2 is used internally.
REQ-010 Debounce FSM SHALL have states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO; counter dcnt, width ceil(log2(DEBOUNCE_CYCLES))+1.
REQ-011 STABLE_LO: sw_s2=1 -> WAIT_HI, dcnt=1; else hold, dcnt=0.
REQ-012 WAIT_HI: sw_s2=0 -> STABLE_LO, dcnt=0 (glitch rejected, mode unchanged); sw_s2=1 and dcnt<DEBOUNCE_CYCLES-1 -> dcnt+1; sw_s2=1 and dcnt=DEBOUNCE_CYCLES-1 -> STABLE_HI, mode<=1, mode_changed<=1, dcnt=0.
REQ-013 STABLE_HI and WAIT_LO SHALL mirror REQ-011/012 with polarities inverted, ending with mode<=0.
REQ-014 Latency: with sw stable after a change, mode SHALL update on exactly the (2+DEBOUNCE_CYCLES)th rising edge after the first edge sampling the new sw level.
REQ-015 Any bounce shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on mode or mode_changed.
REQ-016 mode_changed SHALL be high for exactly one cycle per accepted transition and never otherwise.
REQ-017 Prescaler pcnt, width ceil(log2(TICK_DIV)), SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-018 tick SHALL be a registered output, high for exactly one cycle on the edge where pcnt wraps from TICK_DIV-1 to 0; period TICK_DIV cycles in steady state.
REQ-019 On the edge where mode_changed is set, pcnt SHALL load 0 and tick SHALL be 0 that cycle, even if pcnt was TICK_DIV-1 (mode change has priority).
REQ-020 After REQ-019 restart, next tick SHALL occur exactly TICK_DIV cycles later.
REQ-021 mode, tick, mode_changed SHALL all be driven directly from flops (no combinational output paths).

Reset
REQ-022 reset high SHALL immediately, without clk, force sw_s1=0, sw_s2=0, state=STABLE_LO, dcnt=0, pcnt=0, mode=0, tick=0, mode_changed=0.
REQ-023 reset asserted mid-debounce (WAIT_HI/WAIT_LO) SHALL discard the pending transition; no mode_changed pulse after release.
REQ-024 After reset release, first tick SHALL occur on the TICK_DIV-th rising edge; if sw=1 at release, mode SHALL rise per REQ-014 with one mode_changed pulse.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8, 20 ns clk)
REQ-025 reset=1 for 30 ns with sw=0, release -> mode=0, mode_changed=0, tick pulses on edges 8,16,24 after release.
REQ-026 sw 0->1 clean, held -> mode=1 and one mode_changed pulse on 6th edge after change; next tick exactly 8 edges later.
REQ-027 sw pulses high for 2 cycles then low -> mode stays 0, no mode_changed, tick cadence undisturbed.
REQ-028 sw bounces 1,0,1,0 at 1-cycle spacing then holds 1 -> single mode_changed, mode=1 exactly 6 edges after final stable transition.
REQ-029 accepted change coinciding with pcnt=7 -> tick=0 that cycle, pcnt=0, next tick 8 edges later.
REQ-030 reset asserted 2 cycles into WAIT_HI -> all outputs 0 asynchronously; with sw=0 at release, no mode_changed thereafter.
